// File: rtl/latch_pulse_arbiter_if.sv
// Requester, latch-readback and latch-drive signals shared between the arbiter and its environment.
interface latch_pulse_arbiter_if;
  logic       req0;
  logic       req1;
  logic [1:0] sel0;
  logic [1:0] sel1;
  logic       val0;
  logic       val1;
  logic [3:0] q;
  logic       gnt0;
  logic       gnt1;
  logic       S;
  logic       R;
  logic [3:0] en;
  logic       busy;
  logic       err;

  modport master (
    output req0, req1, sel0, sel1, val0, val1, q,
    input  gnt0, gnt1, S, R, en, busy, err
  );

  modport slave (
    input  req0, req1, sel0, sel1, val0, val1, q,
    output gnt0, gnt1, S, R, en, busy, err
  );
endinterface

// File: rtl/latch_pulse_arbiter.sv
// Round-robin writer of two requesters into four SR latches via a setup/pulse/hold sequence.
// All outputs registered; gnt after SETUP_CYC+PULSE_CYC+HOLD_CYC cycles, new requests ignored while busy.
module latch_pulse_arbiter #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2
) (
  input logic                  clk,
  input logic                  rst,
  latch_pulse_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic       val_q, val_nxt;
  logic       who_q, who_nxt;
  logic       last_q, last_nxt;
  logic       pick1;
  logic       done_nxt;
  logic       s_nxt, r_nxt, busy_nxt, gnt0_nxt, gnt1_nxt, err_nxt;
  logic [3:0] en_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_q;
    val_nxt   = val_q;
    who_nxt   = who_q;
    last_nxt  = last_q;
    // last_q remembers who was granted most recently; the other side wins a tie
    pick1     = bus.req1 && (!bus.req0 || !last_q);

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          who_nxt   = pick1;
          last_nxt  = pick1;
          sel_nxt   = pick1 ? bus.sel1 : bus.sel0;
          val_nxt   = pick1 ? bus.val1 : bus.val0;
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      PULSE: begin
        if (cnt == 8'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it
    done_nxt = (state_nxt == HOLD) && (cnt_nxt == 8'd0);
    busy_nxt = (state_nxt != IDLE);
    s_nxt    = busy_nxt && val_nxt;
    r_nxt    = busy_nxt && !val_nxt;
    en_nxt   = (state_nxt == PULSE) ? 4'(4'b0001 << sel_nxt) : 4'b0000;
    gnt0_nxt = done_nxt && !who_nxt;
    gnt1_nxt = done_nxt && who_nxt;
    err_nxt  = done_nxt && (bus.q[sel_nxt] != val_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      sel_q    <= 2'd0;
      val_q    <= 1'b0;
      who_q    <= 1'b0;
      last_q   <= 1'b1;
      bus.S    <= 1'b0;
      bus.R    <= 1'b0;
      bus.en   <= 4'b0000;
      bus.busy <= 1'b0;
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sel_q    <= sel_nxt;
      val_q    <= val_nxt;
      who_q    <= who_nxt;
      last_q   <= last_nxt;
      bus.S    <= s_nxt;
      bus.R    <= r_nxt;
      bus.en   <= en_nxt;
      bus.busy <= busy_nxt;
      bus.gnt0 <= gnt0_nxt;
      bus.gnt1 <= gnt1_nxt;
      bus.err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_latch_pulse_arbiter.sv
// Bench for latch_pulse_arbiter: vector table, directed corner sequences, random traffic vs a transaction model.
module tb_latch_pulse_arbiter;
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 2;
  localparam int HOLD_CYC  = 2;
  localparam int TOT       = SETUP_CYC + PULSE_CYC + HOLD_CYC;

  logic clk = 1'b0;
  logic rst;
  latch_pulse_arbiter_if b ();

  latch_pulse_arbiter #(
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  always #5 clk = ~clk;

  // Four SR latches; a stuck bit pins that latch's Q low
  logic [3:0] mem;
  logic [3:0] stuck;
  assign b.q = ~stuck & ((b.en & {4{b.S}}) | (~b.en & mem));
  always @(posedge clk) begin
    if (rst) mem <= 4'b0000;
    else     mem <= (b.en & {4{b.S}}) | (~b.en & mem);
  end

  typedef struct {
    logic [8:0] in;   // rst req0 req1 sel0 sel1 val0 val1
    logic [9:0] out;  // busy S R en gnt0 gnt1 err
  } vec_t;

  vec_t tbl[18];
  int   checks = 0;
  int   errors = 0;
  logic p_s = 1'b0, p_r = 1'b0;

  // Transaction model: m_k counts cycles since the grant edge, 1..TOT
  bit       m_act = 1'b0;
  int       m_k = 0;
  bit [1:0] m_sel;
  bit       m_val, m_who;
  bit       m_last = 1'b1;

  int  order[$];
  int  n, extra;
  bit  gap_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_act  = 1'b0;
      m_k    = 0;
      m_last = 1'b1;
    end else if (m_act) begin
      if (m_k == TOT) m_act = 1'b0;
      else            m_k++;
    end else if (b.req0 || b.req1) begin
      m_who  = (b.req0 && b.req1) ? ~m_last : b.req1;
      m_sel  = m_who ? b.sel1 : b.sel0;
      m_val  = m_who ? b.val1 : b.val0;
      m_last = m_who;
      m_act  = 1'b1;
      m_k    = 1;
    end
  endtask

  function automatic logic [9:0] model_out();
    logic       pulse;
    logic       done;
    logic [3:0] en;
    pulse = m_act && (m_k > SETUP_CYC) && (m_k <= SETUP_CYC + PULSE_CYC);
    done  = m_act && (m_k == TOT);
    en    = pulse ? 4'(1 << m_sel) : 4'b0000;
    return {m_act, m_act & m_val, m_act & ~m_val, en,
            done & ~m_who, done & m_who, done & m_val & stuck[m_sel]};
  endfunction

  function automatic logic [9:0] dut_out();
    return {b.busy, b.S, b.R, b.en, b.gnt0, b.gnt1, b.err};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", 32'(dut_out()), 32'(model_out()));
    chk("en_onehot", 32'($countones(b.en) <= 1), 32'd1);
    if (b.en != 4'b0000) chk("sr_stable", 32'({b.S, b.R}), 32'({p_s, p_r}));
    if (!b.busy) chk("idle_sr", 32'({b.S, b.R}), 32'd0);
    p_s = b.S;
    p_r = b.R;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b.req0 = 1'b0;
    b.req1 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {b.req0, b.req1, b.sel0, b.sel1, b.val0, b.val1} = '0;
    stuck = 4'b0000;

    tbl[0]  = '{9'b1_0_0_00_00_0_0, 10'b0_0_0_0000_0_0_0};
    tbl[1]  = '{9'b0_1_0_10_00_1_0, 10'b1_1_0_0000_0_0_0};
    tbl[2]  = '{9'b0_1_0_01_00_0_0, 10'b1_1_0_0000_0_0_0};
    tbl[3]  = '{9'b0_1_0_01_00_0_0, 10'b1_1_0_0100_0_0_0};
    tbl[4]  = '{9'b0_1_0_01_00_0_0, 10'b1_1_0_0100_0_0_0};
    tbl[5]  = '{9'b0_1_0_01_00_0_0, 10'b1_1_0_0000_0_0_0};
    tbl[6]  = '{9'b0_1_0_01_00_0_0, 10'b1_1_0_0000_1_0_0};
    tbl[7]  = '{9'b0_1_0_01_00_0_0, 10'b0_0_0_0000_0_0_0};
    tbl[8]  = '{9'b0_1_1_01_11_0_1, 10'b1_1_0_0000_0_0_0};
    tbl[9]  = '{9'b0_0_0_00_00_0_0, 10'b1_1_0_0000_0_0_0};
    tbl[10] = '{9'b0_0_0_00_00_0_0, 10'b1_1_0_1000_0_0_0};
    tbl[11] = '{9'b0_0_0_00_00_0_0, 10'b1_1_0_1000_0_0_0};
    tbl[12] = '{9'b0_0_0_00_00_0_0, 10'b1_1_0_0000_0_0_0};
    tbl[13] = '{9'b0_0_0_00_00_0_0, 10'b1_1_0_0000_0_1_0};
    tbl[14] = '{9'b0_1_0_01_00_0_0, 10'b0_0_0_0000_0_0_0};
    tbl[15] = '{9'b0_1_0_01_00_0_0, 10'b1_0_1_0000_0_0_0};
    tbl[16] = '{9'b1_1_0_01_00_0_0, 10'b0_0_0_0000_0_0_0};
    tbl[17] = '{9'b0_0_0_00_00_0_0, 10'b0_0_0_0000_0_0_0};

    for (int i = 0; i < 18; i++) begin
      {rst, b.req0, b.req1, b.sel0, b.sel1, b.val0, b.val1} = tbl[i].in;
      step();
      chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].out));
    end

    // Simultaneous requests after reset: 0 first, 1 second, idle gap, one grant each
    do_reset();
    b.req0 = 1'b1; b.sel0 = 2'd0; b.val0 = 1'b1;
    b.req1 = 1'b1; b.sel1 = 2'd1; b.val1 = 1'b1;
    order.delete();
    gap_seen = 1'b0;
    n = 0;
    while (n < 40 && order.size() < 2) begin
      step();
      n++;
      if (b.gnt0) begin order.push_back(0); b.req0 = 1'b0; end
      if (b.gnt1) begin order.push_back(1); b.req1 = 1'b0; end
      if (order.size() == 1 && !b.busy) gap_seen = 1'b1;
    end
    chk("pair_ngrants", 32'(order.size()), 32'd2);
    chk("pair_first", 32'(order.size() > 0 ? order[0] : 9), 32'd0);
    chk("pair_second", 32'(order.size() > 1 ? order[1] : 9), 32'd1);
    chk("pair_gap", 32'(gap_seen), 32'd1);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (b.gnt0 || b.gnt1) extra++;
    end
    chk("pair_no_extra", 32'(extra), 32'd0);

    // Continuous requests from both: strict alternation
    do_reset();
    b.req0 = 1'b1; b.req1 = 1'b1;
    order.delete();
    for (int i = 0; i < 80; i++) begin
      b.sel0 = 2'($urandom_range(0, 3)); b.val0 = 1'($urandom_range(0, 1));
      b.sel1 = 2'($urandom_range(0, 3)); b.val1 = 1'($urandom_range(0, 1));
      step();
      if (b.gnt0) order.push_back(0);
      if (b.gnt1) order.push_back(1);
    end
    chk("alt_count_ge4", 32'(order.size() >= 4), 32'd1);
    chk("alt_first", 32'(order.size() > 0 ? order[0] : 9), 32'd0);
    for (int i = 1; i < order.size(); i++)
      chk($sformatf("alt_%0d", i), 32'(order[i]), 32'(1 - order[i-1]));

    // Stuck latch: err coincident with gnt, one cycle only
    do_reset();
    stuck = 4'b0100;
    b.req0 = 1'b1; b.sel0 = 2'd2; b.val0 = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!b.gnt0 && n < 30);
    b.req0 = 1'b0;
    chk("stuck_gnt", 32'(b.gnt0), 32'd1);
    chk("stuck_err", 32'(b.err), 32'd1);
    step();
    chk("stuck_err_once", 32'({b.err, b.gnt0}), 32'd0);
    stuck = 4'b0000;

    // Reset in the middle of PULSE aborts without a grant
    do_reset();
    b.req0 = 1'b1; b.sel0 = 2'd3; b.val0 = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (b.en == 4'b0000 && n < 20);
    chk("abort_in_pulse", 32'(b.en), 32'h8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    b.req0 = 1'b0;
    chk("abort_outputs", 32'(dut_out()), 32'd0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (b.gnt0 || b.gnt1) extra++;
    end
    chk("abort_no_gnt", 32'(extra), 32'd0);

    // Random traffic; requesters hold req until granted, latches go stuck in the second half
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      if (!b.req0 || b.gnt0) b.req0 = ($urandom_range(0, 1) == 1);
      if (!b.req1 || b.gnt1) b.req1 = ($urandom_range(0, 1) == 1);
      b.sel0 = 2'($urandom_range(0, 3)); b.val0 = 1'($urandom_range(0, 1));
      b.sel1 = 2'($urandom_range(0, 3)); b.val1 = 1'($urandom_range(0, 1));
      if (!b.busy) stuck = (i > 1500) ? 4'($urandom_range(0, 15)) : 4'b0000;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
